// File: rtl/fab_reset_sequencer.sv
// Fabric reset sequencer: synchronizes the CCC lock, qualifies it for a stable
// window, holds SYS_RESET for a fixed period, then releases downstream logic.
module fab_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_STABLE = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       FAB_CLK,
    input  logic       FAB_RESET,
    input  logic       FAB_LOCK,
    input  logic       SW_RESET_REQ,
    output logic       SYS_RESET,
    output logic       READY,
    output logic [7:0] LOSS_COUNT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lock_s;
    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [7:0]             loss_q, loss_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], FAB_LOCK};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s)                  state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s)                state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
                // Lock loss outranks a software request arriving in the same cycle.
                if (!lock_s)          state_d = FAULT;
                else if (SW_RESET_REQ) state_d = HOLD;
            end
            FAULT:   state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
        if (state_d != state_q) cnt_d = '0;

        loss_d = loss_q;
        if ((state_d == FAULT) && (state_q != FAULT) && (loss_q != 8'hFF))
            loss_d = loss_q + 8'd1;

        sys_reset_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
    end

    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            sync_q      <= '0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            loss_q      <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    assign SYS_RESET  = sys_reset_q;
    assign READY      = ready_q;
    assign LOSS_COUNT = loss_q;
    assign STATE      = 3'(state_q);

endmodule

// File: tb/tb_fab_reset_sequencer.sv
// Directed bench for fab_reset_sequencer with an elapsed-time reference model.
module tb_fab_reset_sequencer;

    localparam int SS = 2;
    localparam int LS = 8;
    localparam int HC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       sw;
    logic       sys_reset;
    logic       ready;
    logic [7:0] loss_count;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    fab_reset_sequencer #(
        .SYNC_STAGES(SS),
        .LOCK_STABLE(LS),
        .HOLD_CYCLES(HC)
    ) dut (
        .FAB_CLK     (clk),
        .FAB_RESET   (rst),
        .FAB_LOCK    (lock),
        .SW_RESET_REQ(sw),
        .SYS_RESET   (sys_reset),
        .READY       (ready),
        .LOSS_COUNT  (loss_count),
        .STATE       (state)
    );

    always #5 clk = ~clk;

    // Model: m_t counts edges since qualification began (-1 = waiting for lock).
    // 0..LS-1 is the stable window, LS..LS+HC-1 the hold window, LS+HC is running.
    logic [SS-1:0] m_hist;
    int            m_t;
    bit            m_fault;
    int            m_loss;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist  <= '0;
            m_t     <= -1;
            m_fault <= 1'b0;
            m_loss  <= 0;
        end else begin
            bit ls;
            int nt;
            bit nf;
            int nl;
            ls = m_hist[SS-1];
            nt = m_t;
            nf = 1'b0;
            nl = m_loss;
            if (m_fault) begin
                nt = -1;
            end else if (m_t < 0) begin
                if (ls) nt = 0;
            end else if (!ls) begin
                if (m_t >= LS + HC) begin
                    nf = 1'b1;
                    if (nl < 255) nl = nl + 1;
                end
                nt = -1;
            end else if (m_t >= LS + HC) begin
                if (sw) nt = LS;
            end else begin
                nt = m_t + 1;
            end
            m_hist  <= {m_hist[SS-2:0], lock};
            m_t     <= nt;
            m_fault <= nf;
            m_loss  <= nl;
        end
    end

    function automatic int exp_state();
        if (m_fault)          return 4;
        if (m_t < 0)          return 0;
        if (m_t < LS)         return 1;
        if (m_t < LS + HC)    return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_state", int'(state), exp_state());
        chk("model_sys_reset", int'(sys_reset), (exp_state() != 3) ? 1 : 0);
        chk("model_ready", int'(ready), (exp_state() == 3) ? 1 : 0);
        chk("model_loss", int'(loss_count), m_loss);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input int max_edges);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max_edges; i++) begin
            edges(1);
            if (state == 3'd3) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk("run_timeout", 0, 1);
    endtask

    initial begin
        rst  = 1'b1;
        lock = 1'b0;
        sw   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sys_reset", int'(sys_reset), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_loss", int'(loss_count), 0);

        // Clean lock rise just before edge 1.
        rst  = 1'b0;
        lock = 1'b1;
        edges(3);  chk("e3_stable", int'(state), 1);
        edges(7);  chk("e10_stable", int'(state), 1);
        edges(1);  chk("e11_hold", int'(state), 2);
        edges(15); chk("e26_hold", int'(state), 2);
        chk("e26_sys_reset", int'(sys_reset), 1);
        edges(1);  chk("e27_run", int'(state), 3);
        chk("e27_sys_reset", int'(sys_reset), 0);
        chk("e27_ready", int'(ready), 1);

        // Software request: 16 cycles of hold, then run again.
        sw = 1'b1;
        edges(1);
        sw = 1'b0;
        chk("sw_hold", int'(state), 2);
        chk("sw_sys_reset", int'(sys_reset), 1);
        edges(15); chk("sw_hold_last", int'(state), 2);
        edges(1);  chk("sw_back_run", int'(state), 3);

        // Lock loss in run: fault three edges later.
        lock = 1'b0;
        edges(2);  chk("loss_still_run", int'(state), 3);
        edges(1);  chk("loss_fault", int'(state), 4);
        chk("loss_sys_reset", int'(sys_reset), 1);
        chk("loss_count1", int'(loss_count), 1);
        edges(1);  chk("loss_wait", int'(state), 0);

        // One-cycle low captured while stable with cnt=5.
        lock = 1'b1;
        edges(3);  chk("g_stable", int'(state), 1);
        edges(3);
        lock = 1'b0;
        edges(1);
        lock = 1'b1;
        edges(1);  chk("g_still_stable", int'(state), 1);
        edges(1);  chk("g_wait", int'(state), 0);
        edges(1);  chk("g_restable", int'(state), 1);
        edges(7);  chk("g_stable_end", int'(state), 1);
        edges(1);  chk("g_hold", int'(state), 2);
        edges(15); chk("g_hold_end", int'(state), 2);
        edges(1);  chk("g_run", int'(state), 3);
        chk("g_loss_unchanged", int'(loss_count), 1);

        // Software request in the same cycle lock_s falls.
        lock = 1'b0;
        edges(2);
        sw = 1'b1;
        edges(1);
        sw = 1'b0;
        chk("both_fault", int'(state), 4);
        chk("both_loss2", int'(loss_count), 2);
        edges(1);

        // 298 more loss events, 300 in total.
        for (int i = 0; i < 298; i++) begin
            lock = 1'b1;
            wait_run(60);
            lock = 1'b0;
            edges(4);
            if (i == 252) chk("loss_at_255", int'(loss_count), 255);
        end
        chk("loss_saturated", int'(loss_count), 255);

        // Asynchronous reset mid-hold.
        lock = 1'b1;
        edges(3 + 8 + 3);
        chk("pre_rst_hold", int'(state), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sys_reset", int'(sys_reset), 1);
        chk("arst_ready", int'(ready), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_loss", int'(loss_count), 0);

        // Asynchronous reset while running.
        edges(1);
        rst = 1'b0;
        wait_run(40);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_run_sys_reset", int'(sys_reset), 1);
        chk("arst_run_ready", int'(ready), 0);
        edges(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
